// File: rtl/data_mem_ctrl_if.sv
// Bus between data_cache/data memory (master side) and data_mem_ctrl (slave side).
// Carries the miss request, the victim description, the fill return and the memory port.
interface data_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_be;
  logic            victim_dirty;
  logic [XLEN-1:0] victim_addr;
  logic [XLEN-1:0] victim_data;
  logic            stall;
  logic            fill_valid;
  logic [XLEN-1:0] fill_data;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_we;
  logic            mem_re;
  logic [XLEN-1:0] mem_rdata;

  // Cache and memory side: raises misses, supplies read data, sees stall/fill/strobes
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    output victim_dirty, victim_addr, victim_data, mem_rdata,
    input  stall, fill_valid, fill_data,
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    input  victim_dirty, victim_addr, victim_data, mem_rdata,
    output stall, fill_valid, fill_data,
    output mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: miss/refill controller between data_cache and a fixed-latency data memory.
// Load miss: optional writeback of the dirty victim, then a word fetch returned as fill data.
// Store miss: forwarded straight to memory (write-no-allocate).
// Optional feature macro WB_BUFFER_EN: one-entry writeback buffer so a dirty load miss
// fetches first and the victim drains later; loads hitting the buffered victim are served
// from the buffer. Without the macro the writeback is done serially before the fill.
module data_mem_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int              CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

`ifdef WB_BUFFER_EN
  typedef enum logic [2:0] {IDLE, WB, FILL, WRITE, DONE, DRAIN} state_e;
`else
  typedef enum logic [2:0] {IDLE, WB, FILL, WRITE, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [XLEN-1:0]  fill_data_q, fill_data_d;
`ifdef WB_BUFFER_EN
  logic             wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]  wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
`else
  logic [XLEN-1:0]  vaddr_q, vaddr_d;
  logic [XLEN-1:0]  vdata_q, vdata_d;
`endif
  logic             cnt_last;

  // State, strobe counter and latched request/victim; reset drops any op in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      fill_data_q <= '0;
`ifdef WB_BUFFER_EN
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
`else
      vaddr_q     <= '0;
      vdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      fill_data_q <= fill_data_d;
`ifdef WB_BUFFER_EN
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
`else
      vaddr_q     <= vaddr_d;
      vdata_q     <= vdata_d;
`endif
    end
  end

  // Next-state, memory strobes and handshake outputs; strobes decode from state only
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_d         = load_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    fill_data_d    = fill_data_q;
`ifdef WB_BUFFER_EN
    wb_valid_d     = wb_valid_q;
    wb_addr_d      = wb_addr_q;
    wb_data_d      = wb_data_q;
`else
    vaddr_d        = vaddr_q;
    vdata_d        = vdata_q;
`endif
    cnt_last       = (cnt_q == CNT_LAST);
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_be     = 4'h0;
    bus.fill_valid = 1'b0;
    bus.fill_data  = fill_data_q;
    bus.stall      = rst && bus.req_valid && (state_q != DONE);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef WB_BUFFER_EN
        if (wb_valid_q) begin
          if (bus.req_valid && !bus.req_we &&
              (bus.req_addr[XLEN-1:2] == wb_addr_q[XLEN-1:2])) begin
            fill_data_d = wb_data_q;
            load_d      = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else
`endif
        if (bus.req_valid) begin
          addr_d  = bus.req_addr & WORD_MASK;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          load_d  = !bus.req_we;
          if (bus.req_we) begin
            state_d = WRITE;
          end else if (bus.victim_dirty) begin
`ifdef WB_BUFFER_EN
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.victim_addr & WORD_MASK;
            wb_data_d  = bus.victim_data;
            state_d    = FILL;
`else
            vaddr_d = bus.victim_addr & WORD_MASK;
            vdata_d = bus.victim_data;
            state_d = WB;
`endif
          end else begin
            state_d = FILL;
          end
        end
      end
`ifndef WB_BUFFER_EN
      WB: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = vaddr_q;
        bus.mem_wdata = vdata_q;
        bus.mem_be    = 4'hF;
        cnt_d         = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) state_d = FILL;
      end
`endif
      FILL: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = addr_q;
        cnt_d        = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
          fill_data_d = bus.mem_rdata;
          state_d     = DONE;
        end
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_be    = be_q;
        cnt_d         = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        bus.fill_valid = load_q;
        state_d        = IDLE;
      end
`ifdef WB_BUFFER_EN
      DRAIN: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_addr_q;
        bus.mem_wdata = wb_data_q;
        bus.mem_be    = 4'hF;
        cnt_d         = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
